uart_rx_oversampler: RTL and testbench
======================================

Name: uart_rx_oversampler

Overview:
Parametrised successor to the UART RX data-sampling stage. Captures 1, 3 or 5 samples of rx_in, centred on the mid-bit edge count, and majority-votes them into one bit. Adds a one-cycle valid strobe, a noise flag and an abort path. Sits between the edge/bit counter and the deserializer, start-check, parity-check and stop-check blocks.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt; supports oversampling ratios up to 2^PRESCALE_W-1.
MAX_SAMPLES, 5, largest supported vote size; legal values are 1, 3, 5. Requests above this are clamped to it.

Ports:
clk  input  1  system clock; all state on the rising edge.
rst  input  1  asynchronous, active-low reset.
sample_data_en  input  1  sampling window enable from the RX FSM.
edge_cnt  input  PRESCALE_W  oversampling edge counter; increments once per clk within a bit and wraps at prescale-1.
prescale  input  PRESCALE_W  oversampling ratio.
sample_sel  input  2  vote size: 00=1, 01=3, 10=5, 11=3.
rx_in  input  1  serial line, already synchronised upstream.
sampled_bit  output  1  voted bit value; holds between updates.
sampled_valid  output  1  one-cycle strobe; sampled_bit and noise_flag are updated in this cycle.
noise_flag  output  1  samples in the last vote were not unanimous; qualified by sampled_valid.

Behaviour:
- Reset values: sampled_bit=1, sampled_valid=0, noise_flag=0, FSM=IDLE, all counters=0.
- centre = (prescale>>1)-1, computed in PRESCALE_W bits.
- Effective sample count N = requested count, clamped to MAX_SAMPLES, then reduced until the window fits:
  - N=5 needs prescale>=8.
  - N=3 needs prescale>=4.
  - N=1 needs prescale>=2.
  - prescale<2: no sampling and no valid is ever produced.
- Sample window: edge_cnt = centre-(N-1)/2 through centre+(N-1)/2, one sample per consecutive edge_cnt value.
- FSM states: IDLE, COLLECT, VOTE.
- IDLE:
  - When sample_data_en=1 and edge_cnt==first window position: capture rx_in, then go to COLLECT.
  - On that capture, latch N, the window end position and the first sample, with ones_cnt=rx_in and samp_cnt=1.
  - If N=1, go directly to VOTE instead.
- COLLECT:
  - Each cycle edge_cnt equals the next expected position: increment samp_cnt and add rx_in to ones_cnt.
  - When samp_cnt reaches N: go to VOTE.
- VOTE (exactly one cycle), then return to IDLE:
  - sampled_bit = (ones_cnt > N>>1).
  - noise_flag = (ones_cnt != 0 and ones_cnt != N).
  - sampled_valid = 1.
- Latency: sampled_valid rises on the clock edge after the cycle holding the last window sample, i.e. one cycle after edge_cnt = window end.
- Abort: in COLLECT, if sample_data_en drops, or edge_cnt differs from the expected position (skip or wrap), return to IDLE.
  - On abort: counters cleared, no valid, sampled_bit and noise_flag unchanged.
  - If the abort cycle itself has edge_cnt == first position with sample_data_en=1, restart collection in that cycle.
- prescale and sample_sel are sampled only at window start. Changes mid-window take effect at the next bit.
- ones_cnt and samp_cnt are 3 bits wide; no overflow is possible with N<=5.
- sampled_valid is never high in two consecutive cycles.
- Reset asserted mid-window: immediate return to reset values; no valid is emitted.

Test Plan:
1. prescale=8, sample_sel=01, rx_in=0 at edge_cnt 2,3,4 -> sampled_valid one cycle after edge_cnt=4, sampled_bit=0, noise_flag=0.
2. prescale=16, sample_sel=10, samples at edge_cnt 5..9 = 1,0,1,1,0 -> sampled_bit=1, noise_flag=1, single valid pulse.
3. prescale=4, sample_sel=10 (clamped to N=3), window edge_cnt 0..2, samples 0,1,0 -> sampled_bit=0, noise_flag=1. Then prescale=6, sample_sel=10 -> N=3, window 1..3.
4. prescale=8, sample_sel=01, sample_data_en dropped at edge_cnt=3 -> no valid; sampled_bit stays at its prior value 1; next full window votes normally.
5. prescale=32, sample_sel=00, rx_in=0 only at edge_cnt=15 -> sampled_bit=0, noise_flag=0. rst pulsed low during a 5-sample window -> outputs return to 1/0/0 with no valid.
6. Back-to-back bits with prescale=8, N=3 across 10 wraps of edge_cnt with random rx_in -> exactly 10 valid pulses, each equal to the majority of that bit's samples.

Source files
------------

// File: rtl/uart_rx_oversampler.sv
// UART RX data-sampling stage: takes 1, 3 or 5 samples of rx_in centred on
// the mid-bit edge count and majority-votes them into one bit, with a
// one-cycle valid strobe, a non-unanimous (noise) flag and an abort path.
module uart_rx_oversampler #(
    parameter int PRESCALE_W  = 6,
    parameter int MAX_SAMPLES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_data_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            sample_sel,
    input  logic                  rx_in,
    output logic                  sampled_bit,
    output logic                  sampled_valid,
    output logic                  noise_flag
);

    localparam logic [2:0]            MAX_N = 3'(MAX_SAMPLES);
    localparam logic [PRESCALE_W-1:0] PS_2  = PRESCALE_W'(2);
    localparam logic [PRESCALE_W-1:0] PS_4  = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] PS_8  = PRESCALE_W'(8);

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            n_q, n_d;
    logic [2:0]            ones_q, ones_d;
    logic [2:0]            samp_q, samp_d;
    logic [PRESCALE_W-1:0] exp_q, exp_d;

    logic [2:0]            n_eff;
    logic [PRESCALE_W-1:0] centre;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] first_pos;
    logic                  start;
    logic                  bit_d, noise_d, valid_d;

    // Requested vote size, clamped to MAX_SAMPLES and shrunk until the
    // window fits inside the bit period; 0 means no sampling at all.
    function automatic logic [2:0] effective_count(
        input logic [1:0]            sel,
        input logic [PRESCALE_W-1:0] ps
    );
        logic [2:0] n;
        case (sel)
            2'b00:   n = 3'd1;
            2'b10:   n = 3'd5;
            default: n = 3'd3;
        endcase
        if (n > MAX_N)                n = MAX_N;
        if (n == 3'd5 && ps < PS_8)   n = 3'd3;
        if (n == 3'd3 && ps < PS_4)   n = 3'd1;
        if (n == 3'd1 && ps < PS_2)   n = 3'd0;
        return n;
    endfunction

    // Window geometry from the live prescale/sample_sel; only used at start.
    always_comb begin
        n_eff  = effective_count(sample_sel, prescale);
        centre = (prescale >> 1) - PRESCALE_W'(1);
        case (n_eff)
            3'd5:    half = PRESCALE_W'(2);
            3'd3:    half = PRESCALE_W'(1);
            default: half = '0;
        endcase
        first_pos = centre - half;
        start     = sample_data_en && (n_eff != 3'd0) && (edge_cnt == first_pos);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and counter updates; an abort may restart in the same cycle.
    always_comb begin
        state_nxt = state;
        n_d       = n_q;
        ones_d    = ones_q;
        samp_d    = samp_q;
        exp_d     = exp_q;
        case (state)
            IDLE: begin
                if (start) begin
                    n_d       = n_eff;
                    ones_d    = {2'b00, rx_in};
                    samp_d    = 3'd1;
                    exp_d     = edge_cnt + PRESCALE_W'(1);
                    state_nxt = (n_eff == 3'd1) ? VOTE : COLLECT;
                end
            end
            COLLECT: begin
                if (sample_data_en && edge_cnt == exp_q) begin
                    ones_d    = ones_q + {2'b00, rx_in};
                    samp_d    = samp_q + 3'd1;
                    exp_d     = exp_q + PRESCALE_W'(1);
                    state_nxt = (samp_q + 3'd1 == n_q) ? VOTE : COLLECT;
                end else if (start) begin
                    n_d       = n_eff;
                    ones_d    = {2'b00, rx_in};
                    samp_d    = 3'd1;
                    exp_d     = edge_cnt + PRESCALE_W'(1);
                    state_nxt = (n_eff == 3'd1) ? VOTE : COLLECT;
                end else begin
                    n_d       = '0;
                    ones_d    = '0;
                    samp_d    = '0;
                    exp_d     = '0;
                    state_nxt = IDLE;
                end
            end
            VOTE: begin
                n_d       = '0;
                ones_d    = '0;
                samp_d    = '0;
                exp_d     = '0;
                state_nxt = IDLE;
            end
            default: begin
                n_d       = '0;
                ones_d    = '0;
                samp_d    = '0;
                exp_d     = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Vote result, computed on the final sample so it lands with the strobe.
    always_comb begin
        valid_d = (state_nxt == VOTE);
        bit_d   = (ones_d > (n_d >> 1));
        noise_d = (ones_d != 3'd0) && (ones_d != n_d);
    end

    // Window counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            ones_q <= '0;
            samp_q <= '0;
            exp_q  <= '0;
        end else begin
            n_q    <= n_d;
            ones_q <= ones_d;
            samp_q <= samp_d;
            exp_q  <= exp_d;
        end
    end

    // Registered outputs; bit and noise hold between votes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit   <= 1'b1;
            sampled_valid <= 1'b0;
            noise_flag    <= 1'b0;
        end else begin
            sampled_valid <= valid_d;
            if (valid_d) begin
                sampled_bit <= bit_d;
                noise_flag  <= noise_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed bits plus randomized bits checked
// against a window/majority model computed from prescale and sample_sel.
module tb_uart_rx_oversampler;

    localparam int MAXS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_data_en = 1'b0;
    logic [5:0] edge_cnt = '0;
    logic [5:0] prescale = 6'd8;
    logic [1:0] sample_sel = 2'b01;
    logic       rx_in = 1'b1;
    logic       sampled_bit;
    logic       sampled_valid;
    logic       noise_flag;

    int checks   = 0;
    int failures = 0;
    int model_bit   = 1;
    int model_noise = 0;

    uart_rx_oversampler #(.PRESCALE_W(6), .MAX_SAMPLES(MAXS)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_data_en(sample_data_en),
        .edge_cnt      (edge_cnt),
        .prescale      (prescale),
        .sample_sel    (sample_sel),
        .rx_in         (rx_in),
        .sampled_bit   (sampled_bit),
        .sampled_valid (sampled_valid),
        .noise_flag    (noise_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Vote size from the rules: requested size, clamped, then shrunk by 2
    // until the bit period is long enough to hold it.
    function automatic int model_n(input int ps, input logic [1:0] sel);
        int n;
        n = (sel == 2'b00) ? 1 : (sel == 2'b10) ? 5 : 3;
        if (n > MAXS) n = MAXS;
        while (n > 0 && ps < 2 * n - ((n == 5) ? 2 : (n == 3) ? 2 : 0)) n -= 2;
        return (n < 0) ? 0 : n;
    endfunction

    task automatic step(input logic en, input logic [5:0] ec, input logic r);
        sample_data_en = en;
        edge_cnt       = ec;
        rx_in          = r;
        @(posedge clk);
        #1;
    endtask

    // Drive one full bit period and compare against the model.
    task automatic run_bit(input int ps, input logic [1:0] sel, input logic [63:0] rxw,
                           input logic [63:0] enw, input string tag, output int nv);
        int cycles, pos, n, first, ones, exp_nv, vb, vn;
        prescale   = 6'(ps);
        sample_sel = sel;
        cycles = (ps < 2) ? 4 : ps;
        nv = 0; pos = -1; vb = 0; vn = 0;
        for (int i = 0; i < cycles; i++) begin
            step(enw[i], (ps < 2) ? 6'd0 : 6'(i), rxw[i]);
            if (sampled_valid) begin
                nv++; pos = i; vb = int'(sampled_bit); vn = int'(noise_flag);
            end
        end
        n = model_n(ps, sel);
        exp_nv = 0; first = 0; ones = 0;
        if (n > 0) begin
            first  = ps / 2 - 1 - (n - 1) / 2;
            exp_nv = 1;
            for (int k = first; k < first + n; k++) begin
                if (!enw[k]) exp_nv = 0;
                ones += int'(rxw[k]);
            end
        end
        chk({tag, "_nvalid"}, nv, exp_nv);
        if (exp_nv == 1) begin
            model_bit   = (ones > n / 2) ? 1 : 0;
            model_noise = (ones != 0 && ones != n) ? 1 : 0;
            chk({tag, "_vpos"}, pos, first + n - 1);
            chk({tag, "_vbit"}, vb, model_bit);
            chk({tag, "_vnoise"}, vn, model_noise);
        end
        chk({tag, "_hold_bit"}, int'(sampled_bit), model_bit);
        chk({tag, "_hold_noise"}, int'(noise_flag), model_noise);
    endtask

    initial begin
        logic [63:0] rxw, enw;
        int nv, total;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit", int'(sampled_bit), 1);
        chk("rst_valid", int'(sampled_valid), 0);
        chk("rst_noise", int'(noise_flag), 0);
        rst = 1'b1;
        step(1'b0, 6'd0, 1'b1);

        // Three zero samples at 2,3,4
        rxw = '1; rxw[2] = 1'b0; rxw[3] = 1'b0; rxw[4] = 1'b0;
        run_bit(8, 2'b01, rxw, '1, "t1", nv);
        chk("t1_bit_const", int'(sampled_bit), 0);

        // Five samples 1,0,1,1,0 at 5..9
        rxw = {$urandom, $urandom};
        rxw[5] = 1'b1; rxw[6] = 1'b0; rxw[7] = 1'b1; rxw[8] = 1'b1; rxw[9] = 1'b0;
        run_bit(16, 2'b10, rxw, '1, "t2", nv);
        chk("t2_noise_const", int'(noise_flag), 1);

        // Clamp to 3 at prescale 4, then window 1..3 at prescale 6
        rxw = '1; rxw[0] = 1'b0; rxw[1] = 1'b1; rxw[2] = 1'b0;
        run_bit(4, 2'b10, rxw, '1, "t3a", nv);
        rxw = {$urandom, $urandom};
        run_bit(6, 2'b10, rxw, '1, "t3b", nv);

        // Abort by dropping enable mid-window, then a normal window
        run_bit(8, 2'b01, '1, '1, "t4pre", nv);
        enw = '1; enw[3] = 1'b0;
        run_bit(8, 2'b01, '0, enw, "t4abort", nv);
        chk("t4_abort_bit", int'(sampled_bit), 1);
        run_bit(8, 2'b01, '0, '1, "t4next", nv);

        // Single sample at the centre
        rxw = '1; rxw[15] = 1'b0;
        run_bit(32, 2'b00, rxw, '1, "t5", nv);

        // Reset mid-window
        prescale = 6'd16; sample_sel = 2'b10;
        for (int i = 0; i < 7; i++) step(1'b1, 6'(i), 1'b1);
        rst = 1'b0;
        #2;
        chk("t5_rst_bit", int'(sampled_bit), 1);
        chk("t5_rst_valid", int'(sampled_valid), 0);
        chk("t5_rst_noise", int'(noise_flag), 0);
        step(1'b1, 6'd7, 1'b1);
        rst = 1'b1;
        model_bit = 1; model_noise = 0;
        nv = 0;
        for (int i = 8; i < 16; i++) begin
            step(1'b1, 6'(i), 1'b0);
            if (sampled_valid) nv++;
        end
        chk("t5_after_rst_nvalid", nv, 0);
        chk("t5_after_rst_bit", int'(sampled_bit), 1);

        // Back-to-back bits
        total = 0;
        for (int b = 0; b < 10; b++) begin
            rxw = {$urandom, $urandom};
            run_bit(8, 2'b01, rxw, '1, "t6", nv);
            total += nv;
        end
        chk("t6_total_valid", total, 10);

        // Random prescale, vote size, data and occasional enable drops
        for (int b = 0; b < 40; b++) begin
            int ps;
            ps  = int'($urandom_range(63, 0));
            rxw = {$urandom, $urandom};
            enw = '1;
            if ($urandom_range(3, 0) == 0) enw[$urandom_range((ps > 0) ? ps - 1 : 0, 0)] = 1'b0;
            run_bit(ps, 2'($urandom_range(3, 0)), rxw, enw, "rnd", nv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
